mem_stage: RTL and testbench

- Memory-access stage; consumes the execute stage's result (ALU result, destination register, regwrite) and forwards it to writeback.
- Drives the data SRAM port: 1-cycle read latency, byte write enables.
- Performs store-lane replication, load byte/halfword extraction with sign/zero extension, and alignment checking.
- Single-entry output buffer with valid/ready handshakes on both sides.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_load_align.sv | 36 +++
 rtl/mem_stage.sv | 110 +++++++++++
 tb/tb_mem_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - memory-op codes, stage states and op classification helpers
package mem_stage_pkg;

   localparam int MEMOP_SIZE = 4;

   typedef enum logic [MEMOP_SIZE-1:0] {
      MEMOP_NONE = 4'd0,
      MEMOP_LW   = 4'd1,
      MEMOP_LB   = 4'd2,
      MEMOP_LBU  = 4'd3,
      MEMOP_LH   = 4'd4,
      MEMOP_LHU  = 4'd5,
      MEMOP_SW   = 4'd6,
      MEMOP_SB   = 4'd7,
      MEMOP_SH   = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      VALID     = 2'd2
   } state_t;

   function automatic logic is_load(input logic [MEMOP_SIZE-1:0] op);
      return (op == MEMOP_LW) || (op == MEMOP_LB) || (op == MEMOP_LBU) ||
             (op == MEMOP_LH) || (op == MEMOP_LHU);
   endfunction

   function automatic logic is_store(input logic [MEMOP_SIZE-1:0] op);
      return (op == MEMOP_SW) || (op == MEMOP_SB) || (op == MEMOP_SH);
   endfunction

   function automatic logic is_misaligned(input logic [MEMOP_SIZE-1:0] op, input logic [1:0] lo);
      return (((op == MEMOP_LW) || (op == MEMOP_SW)) && (lo != 2'b00)) ||
             (((op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH)) && lo[0]);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - little-endian byte/halfword extraction with sign/zero extension
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0]           rdata,
   input  logic [1:0]            addr,
   input  logic [MEMOP_SIZE-1:0] mem_op,
   output logic [31:0]           result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      result = rdata;
      case (mem_op)
         MEMOP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
         MEMOP_LBU: result = {24'h0, byte_sel};
         MEMOP_LH:  result = {{16{half_sel[15]}}, half_sel};
         MEMOP_LHU: result = {16'h0, half_sel};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: SRAM drive, load alignment, single-entry writeback buffer
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [DATA_W-1:0]     ex_alu_result,
   input  logic [DATA_W-1:0]     ex_store_data,
   input  logic [MEMOP_SIZE-1:0] ex_mem_op,
   input  logic [REG_W-1:0]      ex_write_reg,
   input  logic                  ex_regwrite,
   output logic                  data_sram_en,
   output logic [3:0]            data_sram_wen,
   output logic [ADDR_W-1:0]     data_sram_addr,
   output logic [DATA_W-1:0]     data_sram_wdata,
   input  logic [DATA_W-1:0]     data_sram_rdata,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [DATA_W-1:0]     wb_result,
   output logic [REG_W-1:0]      wb_write_reg,
   output logic                  wb_regwrite,
   output logic                  wb_adel,
   output logic                  wb_ades
);

   state_t                state;
   logic [1:0]            pend_lo;
   logic [MEMOP_SIZE-1:0] pend_op;
   logic [DATA_W-1:0]     load_data;
   logic                  accept, op_load, op_store, op_mis;
   logic [1:0]            lo;

   assign lo       = ex_alu_result[1:0];
   assign op_load  = is_load(ex_mem_op);
   assign op_store = is_store(ex_mem_op);
   assign op_mis   = is_misaligned(ex_mem_op, lo);
   assign ex_ready = (state == IDLE) || ((state == VALID) && wb_ready);
   assign accept   = ex_valid && ex_ready;
   assign wb_valid = (state == VALID);

   // SRAM port is driven straight from the execute-side op, only in the accept cycle
   always_comb begin
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      if (accept && !reset) begin
         data_sram_addr = {ex_alu_result[ADDR_W-1:2], 2'b00};
         if (!op_mis && (op_load || op_store))
            data_sram_en = 1'b1;
         if (!op_mis && op_store) begin
            case (ex_mem_op)
               MEMOP_SH: begin
                  data_sram_wen   = lo[1] ? 4'b1100 : 4'b0011;
                  data_sram_wdata = {2{ex_store_data[15:0]}};
               end
               MEMOP_SB: begin
                  data_sram_wen   = 4'b0001 << lo;
                  data_sram_wdata = {4{ex_store_data[7:0]}};
               end
               default: begin
                  data_sram_wen   = 4'b1111;
                  data_sram_wdata = ex_store_data;
               end
            endcase
         end
      end
   end

   mem_load_align u_load_align (
      .rdata  (data_sram_rdata),
      .addr   (pend_lo),
      .mem_op (pend_op),
      .result (load_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         pend_lo      <= 2'b00;
         pend_op      <= '0;
         wb_result    <= '0;
         wb_write_reg <= '0;
         wb_regwrite  <= 1'b0;
         wb_adel      <= 1'b0;
         wb_ades      <= 1'b0;
      end else if (state == LOAD_WAIT) begin
         wb_result <= load_data;
         state     <= VALID;
      end else if (accept) begin
         wb_write_reg <= ex_write_reg;
         wb_adel      <= op_mis && op_load;
         wb_ades      <= op_mis && op_store;
         wb_result    <= ex_alu_result;
         wb_regwrite  <= ex_regwrite && !op_store && !op_mis;
         pend_lo      <= lo;
         pend_op      <= ex_mem_op;
         state        <= (op_load && !op_mis) ? LOAD_WAIT : VALID;
      end else if (state == VALID && wb_ready) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [3:0]  ex_mem_op;
   logic [4:0]  ex_write_reg;
   logic        ex_regwrite;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_result;
   logic [4:0]  wb_write_reg;
   logic        wb_regwrite, wb_adel, wb_ades;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mem_stage dut (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_mem_op(ex_mem_op), .ex_write_reg(ex_write_reg), .ex_regwrite(ex_regwrite),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
      .wb_write_reg(wb_write_reg), .wb_regwrite(wb_regwrite),
      .wb_adel(wb_adel), .wb_ades(wb_ades)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] wr, input logic rw);
      ex_valid      = 1'b1;
      ex_mem_op     = op;
      ex_alu_result = a;
      ex_store_data = sd;
      ex_write_reg  = wr;
      ex_regwrite   = rw;
      #1;
   endtask

   task automatic no_op();
      ex_valid  = 1'b0;
      ex_mem_op = MEMOP_NONE;
      #1;
   endtask

   task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
      drive(op, a, 32'h0, 5'd3, 1'b1);
      check({tag, "_en"}, {31'h0, data_sram_en}, 32'h1);
      check({tag, "_wen"}, {28'h0, data_sram_wen}, 32'h0);
      check({tag, "_addr"}, data_sram_addr, {a[31:2], 2'b00});
      step();
      no_op();
      data_sram_rdata = rd;
      check({tag, "_wait_valid"}, {31'h0, wb_valid}, 32'h0);
      check({tag, "_wait_ready"}, {31'h0, ex_ready}, 32'h0);
      step();
      data_sram_rdata = 32'h0;
      check({tag, "_valid"}, {31'h0, wb_valid}, 32'h1);
      check({tag, "_result"}, wb_result, exp);
      check({tag, "_regwrite"}, {31'h0, wb_regwrite}, 32'h1);
      step();
   endtask

   initial begin
      reset = 1'b1; wb_ready = 1'b1; data_sram_rdata = 32'h0;
      ex_store_data = 32'h0; ex_write_reg = 5'd0; ex_regwrite = 1'b0;
      drive(MEMOP_LW, 32'h100, 32'h0, 5'd1, 1'b1);
      step(); step();
      check("rst_valid", {31'h0, wb_valid}, 32'h0);
      check("rst_ready", {31'h0, ex_ready}, 32'h1);
      check("rst_result", wb_result, 32'h0);
      check("rst_sram_en", {31'h0, data_sram_en}, 32'h0);
      reset = 1'b0;
      no_op();
      step();

      // NONE op
      drive(MEMOP_NONE, 32'h1234_5678, 32'h0, 5'd8, 1'b1);
      check("none_en", {31'h0, data_sram_en}, 32'h0);
      step();
      no_op();
      check("none_valid", {31'h0, wb_valid}, 32'h1);
      check("none_result", wb_result, 32'h1234_5678);
      check("none_wreg", {27'h0, wb_write_reg}, 32'd8);
      check("none_regwrite", {31'h0, wb_regwrite}, 32'h1);
      step();
      check("none_drain", {31'h0, wb_valid}, 32'h0);

      run_load("lb",  MEMOP_LB,  32'h0000_1003, 32'h80AA_BBCC, 32'hFFFF_FF80);
      run_load("lbu", MEMOP_LBU, 32'h0000_1003, 32'h80AA_BBCC, 32'h0000_0080);
      run_load("lh",  MEMOP_LH,  32'h0000_5002, 32'h8001_7FFF, 32'hFFFF_8001);
      run_load("lhu", MEMOP_LHU, 32'h0000_5000, 32'h8001_7FFF, 32'h0000_7FFF);
      run_load("lw",  MEMOP_LW,  32'h0000_5004, 32'h8001_7FFF, 32'h8001_7FFF);

      // SH upper half
      drive(MEMOP_SH, 32'h0000_2002, 32'hDEAD_BEEF, 5'd4, 1'b1);
      check("sh_en", {31'h0, data_sram_en}, 32'h1);
      check("sh_wen", {28'h0, data_sram_wen}, 32'hC);
      check("sh_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      check("sh_addr", data_sram_addr, 32'h0000_2000);
      step();
      no_op();
      check("sh_valid", {31'h0, wb_valid}, 32'h1);
      check("sh_regwrite", {31'h0, wb_regwrite}, 32'h0);
      step();

      drive(MEMOP_SB, 32'h0000_4001, 32'h0000_00A5, 5'd4, 1'b1);
      check("sb_wen", {28'h0, data_sram_wen}, 32'h2);
      check("sb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
      step();

      // LW misaligned, taken back-to-back while the SB result drains
      drive(MEMOP_LW, 32'h0000_3001, 32'h0, 5'd9, 1'b1);
      check("lw_mis_en", {31'h0, data_sram_en}, 32'h0);
      step();
      check("lw_mis_adel", {31'h0, wb_adel}, 32'h1);
      check("lw_mis_result", wb_result, 32'h0000_3001);
      check("lw_mis_regwrite", {31'h0, wb_regwrite}, 32'h0);
      drive(MEMOP_SW, 32'h0000_3002, 32'h1111_2222, 5'd9, 1'b0);
      check("sw_mis_en", {31'h0, data_sram_en}, 32'h0);
      step();
      no_op();
      check("sw_mis_ades", {31'h0, wb_ades}, 32'h1);
      check("sw_mis_adel", {31'h0, wb_adel}, 32'h0);
      step();

      // stall with three NONE ops
      drive(MEMOP_NONE, 32'h1, 32'h0, 5'd1, 1'b1);
      step();
      wb_ready = 1'b0;
      drive(MEMOP_NONE, 32'h2, 32'h0, 5'd2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("stall_ready", {31'h0, ex_ready}, 32'h0);
         check("stall_result", wb_result, 32'h1);
         check("stall_valid", {31'h0, wb_valid}, 32'h1);
         step();
      end
      wb_ready = 1'b1;
      #1;
      check("release_result1", wb_result, 32'h1);
      check("release_ready", {31'h0, ex_ready}, 32'h1);
      step();
      check("b2b_result2", wb_result, 32'h2);
      check("b2b_wreg2", {27'h0, wb_write_reg}, 32'd2);
      drive(MEMOP_NONE, 32'h3, 32'h0, 5'd3, 1'b1);
      step();
      no_op();
      check("b2b_result3", wb_result, 32'h3);
      check("b2b_valid3", {31'h0, wb_valid}, 32'h1);
      step();
      check("b2b_drain", {31'h0, wb_valid}, 32'h0);

      // reset while a load is outstanding
      drive(MEMOP_LW, 32'h0000_6000, 32'h0, 5'd7, 1'b1);
      step();
      no_op();
      reset = 1'b1;
      data_sram_rdata = 32'hCAFE_F00D;
      step();
      check("rlw_valid", {31'h0, wb_valid}, 32'h0);
      check("rlw_ready", {31'h0, ex_ready}, 32'h1);
      check("rlw_result", wb_result, 32'h0);
      reset = 1'b0;
      step();
      check("rlw_after_result", wb_result, 32'h0);
      check("rlw_after_valid", {31'h0, wb_valid}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
